hilo_mul_unit: RTL
==================

Name: hilo_mul_unit

Overview:
- Sequential multiply and HI/LO register block that sits beside the EX-stage ALU32Bit.
- Executes mult, multu, madd, msub, mthi and mtlo over multiple cycles.
- Owns the architectural HI/LO registers and drives the Hi_in/Lo_in values that the ALU reads for mfhi/mflo.
- Raises Stall so the hazard unit can freeze IF/ID/EX while an operation is in flight.

Parameters:
- BITS_PER_CYCLE, 4, multiplier bits retired per iteration; must divide 32 (1, 2, 4, 8).
- ITERS, 32/BITS_PER_CYCLE, derived localparam; not overridable.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  issue request from the EX stage, qualified by HiLoOp.
- HiLoOp  input  3  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MSUB, 5 MTHI, 6 MTLO; 7 is treated as NOP.
- A  input  32  rs operand.
- B  input  32  rt operand.
- HiLoRead  input  1  an mfhi/mflo is in EX this cycle.
- Flush  input  1  abort the in-flight operation (branch/exception squash).
- Hi  output  32  architectural HI; feeds ALU Hi_in.
- Lo  output  32  architectural LO; feeds ALU Lo_in.
- Busy  output  1  an operation is in progress.
- Stall  output  1  pipeline freeze request.
- Done  output  1  one-cycle pulse on the cycle HI/LO are updated.

Behaviour:
- Reset (synchronous, active-high) takes priority over every other input.
  - Hi=0, Lo=0, Busy=0, Stall=0, Done=0, FSM=IDLE.
  - Internal accumulator and counter are cleared.
  - Reset mid-operation discards the operation.
- FSM states are IDLE, ITER and COMMIT.
- IDLE:
  - Start with HiLoOp in MULT/MULTU/MADD/MSUB: latch the operands.
    - MULT/MADD/MSUB: take magnitudes of A and B, and latch sign = A[31]^B[31].
    - MULTU: latch operands unsigned, sign=0.
    - Clear the 64-bit product, set counter=0, go to ITER. Busy goes high the next cycle.
  - Start with MTHI/MTLO: at the next edge Hi<=A (or Lo<=A), Done=1 for that one cycle, stay in IDLE, Busy never asserts.
  - Start with NOP or 7: no effect.
- ITER:
  - Each cycle adds (multiplicand * multiplier[BITS_PER_CYCLE-1:0]) << (counter*BITS_PER_CYCLE) into the 64-bit product, shifts the multiplier right by BITS_PER_CYCLE, and increments the counter.
  - After ITERS cycles, go to COMMIT.
- COMMIT (one cycle):
  - Negate the product if sign=1, giving a 64-bit two's complement result P.
  - MULT/MULTU: {Hi,Lo}<=P.
  - MADD: {Hi,Lo}<={Hi,Lo}+P.
  - MSUB: {Hi,Lo}<={Hi,Lo}-P.
  - 64-bit arithmetic wraps modulo 2^64; there is no overflow flag.
  - Done=1 in the cycle after the edge, then return to IDLE.
- Latency:
  - From the Start edge to the HI/LO update is ITERS+1 cycles (9 at the default).
  - Busy is high from the cycle after Start through the COMMIT cycle.
  - Busy is low in the cycle that Done is high.
- Stall = Busy OR (HiLoRead AND Start-of-multiply this cycle).
  - Stall is combinational from registered Busy plus the two inputs.
  - mfhi/mflo never read a stale HI/LO.
- Start while Busy: ignored. The hazard unit holds the instruction stalled, so it is re-presented once Busy drops.
- MTHI/MTLO while Busy is ignored the same way.
- Flush:
  - In ITER: return to IDLE next cycle, HI/LO unchanged, no Done.
  - In COMMIT: Flush loses; the commit completes because the instruction is already past the squash point.
  - In IDLE: suppresses any same-cycle Start.
- Special operand cases:
  - A=0x80000000 with signed ops: magnitude is 0x80000000 as unsigned 32-bit; the result must be exact.
  - Zero operands follow the normal ITERS latency; there is no early termination.

Decomposition:
- Shared package (mips_pkg) holds:
  - The HILO_NOP..HILO_MTLO op encodings.
  - FSM state constants.
  - Default BITS_PER_CYCLE.
- One sub-module: mul_step, a combinational partial-product adder that takes the 32-bit multiplicand, a BITS_PER_CYCLE multiplier slice, the shift amount and the 64-bit accumulator, and returns the new accumulator. The FSM and HI/LO registers stay in hilo_mul_unit.

Test Plan:
- Reset release, then MULT A=7, B=-3 (0xFFFFFFFD) -> after 9 cycles Done pulses, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 9 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- Sequence:
  - MTHI 0, MTLO 10: each Done in 1 cycle, no Busy.
  - MADD A=3, B=4 -> Hi=0, Lo=22.
  - MSUB A=2, B=20 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEE.
- MULT 0x80000000 * 0x80000000 -> Hi=0x40000000, Lo=0; MULT 0x80000000 * 1 -> Hi=0xFFFFFFFF, Lo=0x80000000.
- MULT 5*5 in flight:
  - HiLoRead held high -> Stall high until Done; a second Start during Busy is ignored, final Lo=25.
  - Flush asserted at ITER cycle 4 -> no Done, Hi/Lo keep prior values.
- Reset asserted at ITER cycle 3 of MADD -> next cycle Hi=Lo=0, Busy=0, and no Done follows.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared HI/LO op encodings, multiplier FSM states and defaults.
// Revision: 1.0
`default_nettype none

package mips_pkg;

  localparam logic [2:0] HILO_NOP   = 3'd0;
  localparam logic [2:0] HILO_MULT  = 3'd1;
  localparam logic [2:0] HILO_MULTU = 3'd2;
  localparam logic [2:0] HILO_MADD  = 3'd3;
  localparam logic [2:0] HILO_MSUB  = 3'd4;
  localparam logic [2:0] HILO_MTHI  = 3'd5;
  localparam logic [2:0] HILO_MTLO  = 3'd6;

  localparam int DEFAULT_BITS_PER_CYCLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_COMMIT = 2'd2
  } hilo_state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) ||
           (op == HILO_MADD) || (op == HILO_MSUB);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mul_unit_mul_step.sv
// mul_step: one radix-2^BITS_PER_CYCLE partial-product accumulate.
// Revision: 1.0
`default_nettype none

module mul_step #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [31:0]               multiplicand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [5:0]                shamt,
  input  logic [63:0]               acc_in,
  output logic [63:0]               acc_out
);

  logic [63:0] partial;

  always_comb begin
    partial = 64'(multiplicand) * 64'(slice);
    acc_out = acc_in + (partial << shamt);
  end

endmodule

`default_nettype wire

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: iterative multiplier owning the architectural HI/LO pair.
// Revision: 1.0
`default_nettype none

module hilo_mul_unit
  import mips_pkg::*;
#(
  parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  HiLoOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoRead,
  input  logic        Flush,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Stall,
  output logic        Done
);

  localparam int ITERS = 32 / BITS_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

  hilo_state_t state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        sign;
  logic [2:0]  op;
  logic [CW-1:0] count;
  logic [63:0] prod;
  logic [63:0] prod_next;
  logic [63:0] p_signed;
  logic [63:0] hilo_new;
  logic [5:0]  shamt;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  assign shamt = 6'(32'(count) * 32'(BITS_PER_CYCLE));

  mul_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .multiplicand(mcand),
    .slice       (mplier[BITS_PER_CYCLE-1:0]),
    .shamt       (shamt),
    .acc_in      (prod),
    .acc_out     (prod_next)
  );

  // Product is accumulated on magnitudes; the sign is applied once at commit.
  always_comb begin
    p_signed = sign ? (~prod + 64'd1) : prod;
    case (op)
      HILO_MADD: hilo_new = {hi_r, lo_r} + p_signed;
      HILO_MSUB: hilo_new = {hi_r, lo_r} - p_signed;
      default:   hilo_new = p_signed;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      sign   <= 1'b0;
      op     <= HILO_NOP;
      count  <= '0;
      prod   <= 64'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !Flush) begin
            if (is_mul_op(HiLoOp)) begin
              if (HiLoOp == HILO_MULTU) begin
                mcand  <= A;
                mplier <= B;
                sign   <= 1'b0;
              end else begin
                mcand  <= abs32(A);
                mplier <= abs32(B);
                sign   <= A[31] ^ B[31];
              end
              op     <= HiLoOp;
              prod   <= 64'd0;
              count  <= '0;
              busy_r <= 1'b1;
              state  <= ST_ITER;
            end else if (HiLoOp == HILO_MTHI) begin
              hi_r   <= A;
              done_r <= 1'b1;
            end else if (HiLoOp == HILO_MTLO) begin
              lo_r   <= A;
              done_r <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          if (Flush) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            prod   <= prod_next;
            mplier <= mplier >> BITS_PER_CYCLE;
            count  <= count + 1'b1;
            if (count == LAST_COUNT) begin
              state <= ST_COMMIT;
            end
          end
        end
        // Flush is ignored here: the instruction is already past the squash point.
        ST_COMMIT: begin
          hi_r   <= hilo_new[63:32];
          lo_r   <= hilo_new[31:0];
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign Hi    = hi_r;
  assign Lo    = lo_r;
  assign Busy  = busy_r;
  assign Done  = done_r;
  assign Stall = busy_r | (HiLoRead & Start & is_mul_op(HiLoOp));

endmodule

`default_nettype wire
